// File: rtl/mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Handshake wrapper around a sequential multiplier: latches
//                operands, holds the multiplier start level, times out a
//                stuck multiplier and buffers the product until consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mlier,
    input  logic [31:0] in_mcand,
    output logic        mul_start,
    output logic [31:0] mul_mlier,
    output logic [31:0] mul_mcand,
    input  logic        mul_valid,
    input  logic [63:0] mul_prodt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_prodt,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_CAPT = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    // Last RUN cycle index before the abort fires (counter starts at zero).
    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_mul_start;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_err_timeout;
    logic [31:0]   r_mul_mlier;
    logic [31:0]   r_mul_mcand;
    logic [63:0]   r_out_prodt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_mul_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_mul_mlier   <= '0;
            r_mul_mcand   <= '0;
            r_out_prodt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_mul_mlier   <= in_mlier;
                        r_mul_mcand   <= in_mcand;
                        r_cnt         <= '0;
                        r_err_timeout <= 1'b0;
                        r_state       <= c_ST_RUN;
                        r_in_ready    <= 1'b0;
                        r_mul_start   <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done flag on the final RUN cycle still wins over abort.
                    if (mul_valid) begin
                        r_state <= c_ST_CAPT;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= c_ST_IDLE;
                        r_mul_start   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_in_ready    <= 1'b1;
                    end
                end
                c_ST_CAPT: begin
                    // The product register settles one cycle after mul_valid.
                    r_out_prodt <= mul_prodt;
                    r_state     <= c_ST_HOLD;
                    r_mul_start <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_mul_start <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign mul_start   = r_mul_start;
    assign mul_mlier   = r_mul_mlier;
    assign mul_mcand   = r_mul_mcand;
    assign out_valid   = r_out_valid;
    assign out_prodt   = r_out_prodt;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Self-checking bench for mul_seq_ctrl with a latency-
//                programmable multiplier stub and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam int TIMEOUT = 40;
    localparam int CW      = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mlier;
    logic [31:0] in_mcand;
    logic        mul_start;
    logic [31:0] mul_mlier;
    logic [31:0] mul_mcand;
    logic        mul_valid;
    logic [63:0] mul_prodt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prodt;
    logic        busy;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clock = ~clock;

    mul_seq_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mlier   (in_mlier),
        .in_mcand   (in_mcand),
        .mul_start  (mul_start),
        .mul_mlier  (mul_mlier),
        .mul_mcand  (mul_mcand),
        .mul_valid  (mul_valid),
        .mul_prodt  (mul_prodt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prodt  (out_prodt),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = $signed({{32{a[31]}}, a});
        y = $signed({{32{b[31]}}, b});
        return 64'(x * y);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stub: done flag after a programmable delay, product one cycle later.
    int st_cnt;
    int st_lat;
    bit st_dead;
    int next_lat  = 2;
    bit next_dead = 1'b0;

    always @(posedge clock) begin
        if (reset || !mul_start) begin
            st_cnt    <= 0;
            mul_valid <= 1'b0;
            mul_prodt <= 64'hDEAD_BEEF_0BAD_F00D;
            st_lat    <= next_lat;
            st_dead   <= next_dead;
        end else begin
            if (st_cnt < 1000) st_cnt <= st_cnt + 1;
            if (!st_dead && st_cnt == st_lat) mul_valid <= 1'b1;
            if (mul_valid) mul_prodt <= smul(mul_mlier, mul_mcand);
        end
    end

    // Transaction-level reference: idle / waiting / capture / holding a result.
    bit          m_busy = 1'b0;
    bit          m_capt = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_err  = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [63:0] m_p = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 1'b0; m_capt = 1'b0; m_hold = 1'b0; m_err = 1'b0;
            m_waited = 0; m_a = '0; m_b = '0; m_p = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_a = in_mlier; m_b = in_mcand; m_err = 1'b0;
                m_busy = 1'b1; m_waited = 0; m_capt = 1'b0; m_hold = 1'b0;
            end
        end else if (m_hold) begin
            if (out_ready) begin
                m_busy = 1'b0; m_hold = 1'b0;
            end
        end else if (m_capt) begin
            m_p = smul(m_a, m_b); m_capt = 1'b0; m_hold = 1'b1;
        end else if (mul_valid) begin
            m_capt = 1'b1;
        end else begin
            m_waited++;
            if (m_waited >= TIMEOUT) begin
                m_err = 1'b1; m_busy = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("in_ready",    in_ready,    !m_busy);
            chk("busy",        busy,        m_busy);
            chk("mul_start",   mul_start,   m_busy && !m_hold);
            chk("out_valid",   out_valid,   m_hold);
            chk("out_prodt",   out_prodt,   m_p);
            chk("mul_mlier",   mul_mlier,   m_a);
            chk("mul_mcand",   mul_mcand,   m_b);
            chk("err_timeout", err_timeout, m_err);
        end
    end

    // Start must stay low for at least two cycles after a delivered result.
    int low_len = 0;
    bit had_result = 1'b0;
    always @(posedge clock) begin
        if (reset || !cmp_en) begin
            low_len = 0; had_result = 1'b0;
        end else begin
            if (mul_start) begin
                if (had_result) begin
                    chk("start_low_gap_ge2", low_len >= 2, 1);
                    had_result = 1'b0;
                end
                low_len = 0;
            end else begin
                low_len++;
            end
            if (out_valid && out_ready) had_result = 1'b1;
        end
    end

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        in_mlier = a; in_mcand = b; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic run_until_out(output int lat_obs, output bit ok);
        int mv_at;
        int i;
        mv_at = -1;
        for (i = 0; i < 200; i++) begin
            if (mul_valid && mv_at < 0) mv_at = i;
            if (out_valid) break;
            @(negedge clock);
        end
        ok = out_valid;
        lat_obs = i - mv_at;
        chk("wait_out_valid", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;
        int runs;
        reset = 1'b1; in_valid = 1'b0; in_mlier = '0; in_mcand = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        cmp_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_prodt", out_prodt, 64'h0);
        reset = 1'b0;
        @(negedge clock);

        // 3 x 5 with consumer always ready
        next_lat = 2; out_ready = 1'b1;
        accept(32'd3, 32'd5);
        run_until_out(lat, ok);
        chk("lat_3x5", lat, 2);
        chk("prod_3x5", out_prodt, 64'h0000_0000_0000_000F);
        @(negedge clock);
        chk("3x5_single_pulse", out_valid, 0);
        chk("3x5_ready_again", in_ready, 1);

        // -1 x 7 with back-pressure; operands offered during HOLD are ignored
        out_ready = 1'b0; next_lat = 5;
        accept(32'hFFFF_FFFF, 32'd7);
        run_until_out(lat, ok);
        chk("lat_m1x7", lat, 2);
        chk("prod_m1x7", out_prodt, 64'hFFFF_FFFF_FFFF_FFF9);
        in_valid = 1'b1; in_mlier = 32'h1234; in_mcand = 32'h5678;
        repeat (5) begin
            @(negedge clock);
            chk("hold_valid", out_valid, 1);
            chk("hold_prodt", out_prodt, 64'hFFFF_FFFF_FFFF_FFF9);
        end
        chk("hold_mlier_kept", mul_mlier, 32'hFFFF_FFFF);
        chk("hold_mcand_kept", mul_mcand, 32'd7);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("m1x7_released", out_valid, 0);

        // back-to-back with in_valid held high
        next_lat = 1;
        in_valid = 1'b1; in_mlier = 32'd2; in_mcand = 32'd3;
        @(negedge clock);
        in_mlier = 32'h0001_0000; in_mcand = 32'h0001_0000;
        run_until_out(lat, ok);
        chk("prod_b2b_first", out_prodt, 64'd6);
        @(negedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        run_until_out(lat, ok);
        chk("prod_b2b_second", out_prodt, 64'h0000_0001_0000_0000);
        @(negedge clock);

        // stub multiplier never finishes: abort after TIMEOUT RUN cycles
        next_dead = 1'b1;
        accept(32'd9, 32'd9);
        runs = 0;
        for (int i = 0; i < 200; i++) begin
            if (err_timeout) break;
            if (mul_start) runs++;
            @(negedge clock);
        end
        chk("timeout_flag", err_timeout, 1);
        chk("timeout_run_cycles", runs, TIMEOUT);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_result", out_valid, 0);
        next_dead = 1'b0; next_lat = 1;
        accept(32'd4, 32'd4);
        chk("timeout_cleared", err_timeout, 0);
        run_until_out(lat, ok);
        chk("prod_4x4", out_prodt, 64'd16);
        @(negedge clock);

        // done flag on the very last RUN cycle beats the abort
        next_lat = TIMEOUT - 2;
        accept(32'd7, 32'd6);
        run_until_out(lat, ok);
        chk("edge_no_err", err_timeout, 0);
        chk("prod_7x6", out_prodt, 64'd42);
        @(negedge clock);
        // one cycle later it is too late
        next_lat = TIMEOUT - 1;
        accept(32'd8, 32'd8);
        for (int i = 0; i < 200 && busy; i++) @(negedge clock);
        chk("late_err", err_timeout, 1);
        chk("late_no_result", out_valid, 0);
        @(negedge clock);

        // reset in the middle of RUN
        next_dead = 1'b1;
        accept(32'd5, 32'd5);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_start", mul_start, 0);
        chk("midrst_in_ready", in_ready, 1);
        next_dead = 1'b0; next_lat = 3;
        accept(32'd2, 32'd2);
        run_until_out(lat, ok);
        chk("prod_2x2", out_prodt, 64'd4);
        @(negedge clock);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in_mlier  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            in_mcand  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 300));
            out_ready = ($urandom_range(0, 1) == 0);
            next_lat  = $urandom_range(0, TIMEOUT);
            next_dead = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            @(negedge clock);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2 * TIMEOUT + 10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: maximum cycles in RUN without mul_valid before abort.
REQ-002 SHALL have parameter CW, default 6: width of the RUN cycle counter; TIMEOUT < 2^CW.
REQ-003 SHALL provide port clock, input, 1: single clock, rising edge.
REQ-004 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1: operand pair offered.
REQ-006 SHALL provide port in_ready, output, 1: block accepts operands.
REQ-007 SHALL provide port in_mlier, input, 32: signed multiplier operand.
REQ-008 SHALL provide port in_mcand, input, 32: signed multiplicand operand.
REQ-009 SHALL provide port mul_start, output, 1: start level to the sequential multiplier; must be held high for the whole operation.
REQ-010 SHALL provide port mul_mlier, output, 32: registered multiplier operand to the multiplier.
REQ-011 SHALL provide port mul_mcand, output, 32: registered multiplicand operand to the multiplier.
REQ-012 SHALL provide port mul_valid, input, 1: multiplier done flag.
REQ-013 SHALL provide port mul_prodt, input, 64: multiplier registered product.
REQ-014 SHALL provide port out_valid, output, 1: result available.
REQ-015 SHALL provide port out_ready, input, 1: consumer accepts result.
REQ-016 SHALL provide port out_prodt, output, 64: captured product.
REQ-017 SHALL provide port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL provide port err_timeout, output, 1: sticky abort flag.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, CAPT, HOLD, all registered.
REQ-020 SHALL drive in_ready high only in IDLE; acceptance is in_valid && in_ready at a rising edge.
REQ-021 On acceptance, SHALL latch in_mlier/in_mcand into mul_mlier/mul_mcand, clear the cycle counter, clear err_timeout, and enter RUN.
REQ-022 SHALL hold mul_mlier/mul_mcand constant from acceptance until the next acceptance.
REQ-023 SHALL drive mul_start as a registered output: high in RUN and CAPT, low in IDLE and HOLD.
REQ-024 In RUN, SHALL increment the counter each cycle; when mul_valid is sampled high, SHALL enter CAPT.
REQ-025 In RUN, if the counter reaches TIMEOUT with mul_valid low, SHALL set err_timeout and go to IDLE with no result produced.
REQ-026 SHALL give mul_valid priority over timeout when both occur in the same cycle.
REQ-027 CAPT SHALL last exactly one cycle; at its end, out_prodt SHALL be loaded from mul_prodt, which lags mul_valid by one cycle, and the FSM SHALL enter HOLD.
REQ-028 In HOLD, SHALL assert out_valid with out_prodt stable; on out_valid && out_ready, SHALL enter IDLE.
REQ-029 out_valid SHALL never drop without a handshake; out_ready is ignored outside HOLD.
REQ-030 mul_start SHALL be low for at least 2 consecutive cycles (HOLD, IDLE) between operations so the multiplier clears its state.
REQ-031 in_valid SHALL be ignored outside IDLE; operands offered then are neither latched nor lost-flagged.
REQ-032 Latency: out_valid SHALL rise 2 cycles after the first cycle mul_valid is sampled high.
REQ-033 SHALL keep out_prodt holding its last captured value until the next CAPT.

Reset
REQ-034 On reset high at a rising edge, SHALL enter IDLE regardless of state, including mid-RUN.
REQ-035 On reset, mul_start, out_valid, busy, and err_timeout SHALL go to 0; mul_mlier, mul_mcand, out_prodt, and the counter SHALL go to 0; in_ready SHALL go to 1.
REQ-036 The multiplier instance SHALL share this reset; no partial result is emitted after a reset.

Verification
REQ-037 in_mlier=3, in_mcand=5, out_ready=1, real multiplier attached -> one out_valid pulse, out_prodt=0x000000000000000F, then in_ready=1.
REQ-038 in_mlier=0xFFFFFFFF (-1), in_mcand=7 -> out_prodt=0xFFFFFFFFFFFFFFF9; out_ready held low 5 cycles -> out_valid and out_prodt stable throughout.
REQ-039 Back-to-back operations with in_valid held high -> mul_start low for at least 2 cycles between runs, and the second result is correct (e.g. 0x10000 x 0x10000 = 0x0000000100000000).
REQ-040 mul_valid tied low (stub multiplier) -> err_timeout=1 after TIMEOUT RUN cycles, FSM in IDLE, out_valid never asserted, and err_timeout cleared on the next acceptance.
REQ-041 Reset asserted 10 cycles into RUN -> next edge: busy=0, mul_start=0, in_ready=1; a following operation 2 x 2 -> out_prodt=4.
REQ-042 in_valid pulsed during RUN/HOLD -> operands ignored; mul_mlier/mul_mcand unchanged.
